// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences one instruction
// over 3-5 states, drives mux selects and write strobes, counts retired instructions.
module multicycle_ctrl #(
    parameter int unsigned CNT_W        = 32,
    parameter bit          ILLEGAL_HALT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEM_ADR = 4'd3,
        MEM_RD  = 4'd4,
        MEM_WB  = 4'd5,
        MEM_WR  = 4'd6,
        R_EX    = 4'd7,
        R_WB    = 4'd8,
        BEQ     = 4'd9,
        JUMP    = 4'd10,
        ADDI_EX = 4'd11,
        ADDI_WB = 4'd12,
        HALT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;
    logic             w_unused_zero;

    // The datapath qualifies pc_write_cond with the zero flag itself.
    assign w_unused_zero = zero;

    assign w_retire = (r_state inside {MEM_WB, R_WB, BEQ, ADDI_WB, JUMP}) ||
                      (r_state == MEM_WR && mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE:    r_state <= FETCH;
                FETCH:   if (mem_ready) r_state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_R:         r_state <= R_EX;
                        OP_LW, OP_SW: r_state <= MEM_ADR;
                        OP_BEQ:       r_state <= BEQ;
                        OP_ADDI:      r_state <= ADDI_EX;
                        OP_J:         r_state <= JUMP;
                        default:      r_state <= ILLEGAL_HALT ? HALT : FETCH;
                    endcase
                end
                MEM_ADR: r_state <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:  if (mem_ready) r_state <= MEM_WB;
                MEM_WB:  r_state <= FETCH;
                MEM_WR:  if (mem_ready) r_state <= FETCH;
                R_EX:    r_state <= R_WB;
                R_WB:    r_state <= FETCH;
                BEQ:     r_state <= FETCH;
                ADDI_EX: r_state <= ADDI_WB;
                ADDI_WB: r_state <= FETCH;
                JUMP:    r_state <= FETCH;
                HALT:    r_state <= HALT;
                default: r_state <= IDLE;
            endcase
            if (w_retire) r_count <= r_count + CNT_W'(1);
        end
    end

    // Outputs decode from the state register; only the FETCH PC/IR loads follow mem_ready.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        halted        = 1'b0;
        case (r_state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            DECODE:  alu_src_b = 2'b11;
            MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            R_EX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDI_WB: reg_write = 1'b1;
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    assign instr_count = r_count;
    assign state       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand sequences for halt/wrap,
// then random stimulus against an instruction-level reference model.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] opcode = '0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;

    logic a_pw, a_pwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_sa, a_hlt;
    logic [1:0] a_sb, a_aop, a_ps;
    logic [31:0] a_cnt;
    logic [3:0] a_state;
    logic b_pw, b_pwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_sa, b_hlt;
    logic [1:0] b_sb, b_aop, b_ps;
    logic [3:0] b_cnt;
    logic [3:0] b_state;
    logic [16:0] a_outs, b_outs;

    assign a_outs = {a_pw, a_pwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_sa, a_sb, a_aop, a_ps, a_hlt};
    assign b_outs = {b_pw, b_pwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_sa, b_sb, b_aop, b_ps, b_hlt};

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(a_pw), .pc_write_cond(a_pwc), .iord(a_iord), .mem_read(a_mrd),
        .mem_write(a_mwr), .ir_write(a_irw), .mem_to_reg(a_m2r), .reg_dst(a_rdst),
        .reg_write(a_rw), .alu_src_a(a_sa), .alu_src_b(a_sb), .alu_op(a_aop),
        .pc_source(a_ps), .halted(a_hlt), .instr_count(a_cnt), .state(a_state)
    );

    multicycle_ctrl #(.CNT_W(4), .ILLEGAL_HALT(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(b_pw), .pc_write_cond(b_pwc), .iord(b_iord), .mem_read(b_mrd),
        .mem_write(b_mwr), .ir_write(b_irw), .mem_to_reg(b_m2r), .reg_dst(b_rdst),
        .reg_write(b_rw), .alu_src_a(b_sa), .alu_src_b(b_sb), .alu_op(b_aop),
        .pc_source(b_ps), .halted(b_hlt), .instr_count(b_cnt), .state(b_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Expected strobes for a state, written straight from the state/output table.
    function automatic logic [16:0] exp_outs(int st, logic mr);
        logic pw, pwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, hlt;
        logic [1:0] sb, aop, ps;
        {pw, pwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, hlt} = '0;
        sb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            1:  begin mrd = 1; sb = 2'b01; pw = mr; irw = mr; end
            2:  sb = 2'b11;
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mrd = 1; io = 1; end
            5:  begin m2r = 1; rw = 1; end
            6:  begin mwr = 1; io = 1; end
            7:  begin sa = 1; aop = 2'b10; end
            8:  begin rdst = 1; rw = 1; end
            9:  begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
            10: begin pw = 1; ps = 2'b10; end
            11: begin sa = 1; sb = 2'b10; end
            12: rw = 1;
            15: hlt = 1;
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, ps, hlt};
    endfunction

    // Instruction-level model: each opcode maps to a list of phases after FETCH, DECODE.
    function automatic int seq_state(logic [5:0] op, bit hmode, int idx);
        int p[$];
        if (idx == 0) return 1;
        if (idx == 1) return 2;
        case (op)
            OP_R:    p = '{7, 8};
            OP_LW:   p = '{3, 4, 5};
            OP_SW:   p = '{3, 6};
            OP_BEQ:  p = '{9};
            OP_ADDI: p = '{11, 12};
            OP_J:    p = '{10};
            default: if (hmode) p = '{15};
        endcase
        if (idx - 2 < p.size()) return p[idx-2];
        return -1;
    endfunction

    function automatic bit legal(logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

    bit              m_boot[2];
    int              m_idx[2];
    logic [5:0]      m_op[2];
    longint unsigned m_cnt[2];
    bit              m_hmode[2] = '{1'b1, 1'b0};
    int              m_w[2] = '{32, 4};

    function automatic int model_state(int m);
        return m_boot[m] ? 0 : seq_state(m_op[m], m_hmode[m], m_idx[m]);
    endfunction

    task automatic model_step(input int m, input logic r, input logic mr, input logic [5:0] op);
        int s;
        if (r) begin
            m_boot[m] = 1; m_idx[m] = 0; m_cnt[m] = 0;
        end else if (m_boot[m]) begin
            m_boot[m] = 0; m_idx[m] = 0;
        end else begin
            s = model_state(m);
            if (m_idx[m] == 1) m_op[m] = op;
            if (s == 15) begin
            end else if ((s == 1 || s == 4 || s == 6) && !mr) begin
            end else begin
                m_idx[m]++;
                if (seq_state(m_op[m], m_hmode[m], m_idx[m]) < 0) begin
                    if (legal(m_op[m])) m_cnt[m] = (m_cnt[m] + 1) & ((64'd1 << m_w[m]) - 1);
                    m_idx[m] = 0;
                end
            end
        end
    endtask

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        int st_a, st_b;
        logic [5:0] nop;

        tbl.push_back('{1'b1, OP_R,    1'b0, 4'd0,  32'd0});
        tbl.push_back('{1'b0, OP_R,    1'b1, 4'd0,  32'd0});
        tbl.push_back('{1'b0, OP_R,    1'b1, 4'd1,  32'd0});
        tbl.push_back('{1'b0, OP_R,    1'b1, 4'd2,  32'd0});
        tbl.push_back('{1'b0, OP_R,    1'b1, 4'd7,  32'd0});
        tbl.push_back('{1'b0, OP_R,    1'b1, 4'd8,  32'd0});
        tbl.push_back('{1'b0, OP_LW,   1'b0, 4'd1,  32'd1});
        tbl.push_back('{1'b0, OP_LW,   1'b1, 4'd1,  32'd1});
        tbl.push_back('{1'b0, OP_LW,   1'b1, 4'd2,  32'd1});
        tbl.push_back('{1'b0, OP_LW,   1'b1, 4'd3,  32'd1});
        tbl.push_back('{1'b0, OP_LW,   1'b0, 4'd4,  32'd1});
        tbl.push_back('{1'b0, OP_LW,   1'b0, 4'd4,  32'd1});
        tbl.push_back('{1'b0, OP_LW,   1'b0, 4'd4,  32'd1});
        tbl.push_back('{1'b0, OP_LW,   1'b1, 4'd4,  32'd1});
        tbl.push_back('{1'b0, OP_LW,   1'b1, 4'd5,  32'd1});
        tbl.push_back('{1'b0, OP_BEQ,  1'b1, 4'd1,  32'd2});
        tbl.push_back('{1'b0, OP_BEQ,  1'b1, 4'd2,  32'd2});
        tbl.push_back('{1'b0, OP_BEQ,  1'b1, 4'd9,  32'd2});
        tbl.push_back('{1'b0, OP_J,    1'b1, 4'd1,  32'd3});
        tbl.push_back('{1'b0, OP_J,    1'b1, 4'd2,  32'd3});
        tbl.push_back('{1'b0, OP_J,    1'b1, 4'd10, 32'd3});
        tbl.push_back('{1'b0, OP_SW,   1'b1, 4'd1,  32'd4});
        tbl.push_back('{1'b0, OP_SW,   1'b1, 4'd2,  32'd4});
        tbl.push_back('{1'b0, OP_SW,   1'b1, 4'd3,  32'd4});
        tbl.push_back('{1'b0, OP_SW,   1'b0, 4'd6,  32'd4});
        tbl.push_back('{1'b0, OP_SW,   1'b1, 4'd6,  32'd4});
        tbl.push_back('{1'b0, OP_ADDI, 1'b1, 4'd1,  32'd5});
        tbl.push_back('{1'b0, OP_ADDI, 1'b1, 4'd2,  32'd5});
        tbl.push_back('{1'b0, OP_ADDI, 1'b1, 4'd11, 32'd5});
        tbl.push_back('{1'b0, OP_ADDI, 1'b1, 4'd12, 32'd5});
        tbl.push_back('{1'b0, OP_LW,   1'b1, 4'd1,  32'd6});
        tbl.push_back('{1'b0, OP_LW,   1'b1, 4'd2,  32'd6});
        tbl.push_back('{1'b0, OP_LW,   1'b1, 4'd3,  32'd6});
        tbl.push_back('{1'b0, OP_LW,   1'b0, 4'd4,  32'd6});
        tbl.push_back('{1'b1, OP_LW,   1'b0, 4'd4,  32'd6});
        tbl.push_back('{1'b0, OP_LW,   1'b1, 4'd0,  32'd0});
        tbl.push_back('{1'b0, OP_LW,   1'b1, 4'd1,  32'd0});

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; opcode = tbl[i].op; mem_ready = tbl[i].mr;
            #1;
            check($sformatf("vec%0d_state", i), 64'(a_state), 64'(tbl[i].st));
            check($sformatf("vec%0d_b_state", i), 64'(b_state), 64'(tbl[i].st));
            check($sformatf("vec%0d_outs", i), 64'(a_outs), 64'(exp_outs(int'(tbl[i].st), tbl[i].mr)));
            check($sformatf("vec%0d_count", i), 64'(a_cnt), 64'(tbl[i].cnt));
        end

        // Illegal opcode: halting instance sticks in HALT, NOP instance refetches.
        apply_reset();
        opcode = OP_BAD; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("illegal_a_state", 64'(a_state), 64'd15);
        check("illegal_a_halted", 64'(a_hlt), 64'd1);
        check("illegal_a_outs", 64'(a_outs), 64'(exp_outs(15, 1'b1)));
        check("illegal_b_state", 64'(b_state), 64'd1);
        check("illegal_b_count", 64'(b_cnt), 64'd0);
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        check("halt_hold_state", 64'(a_state), 64'd15);
        check("halt_hold_count", 64'(a_cnt), 64'd0);

        // Counter wrap on the 4-bit instance: 16 addi instructions of 4 cycles each.
        apply_reset();
        opcode = OP_ADDI; mem_ready = 1'b1;
        repeat (61) @(posedge clk);
        @(negedge clk); #1;
        check("wrap_b_count15", 64'(b_cnt), 64'd15);
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        check("wrap_b_count0", 64'(b_cnt), 64'd0);
        check("wrap_a_count16", 64'(a_cnt), 64'd16);
        check("wrap_state", 64'(a_state), 64'd1);

        // Random phase, both instances tracked by the model from a common reset.
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        model_step(0, 1'b1, 1'b0, opcode);
        model_step(1, 1'b1, 1'b0, opcode);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            st_a = model_state(0);
            st_b = model_state(1);
            rst = ($urandom_range(0, 79) == 0) || (st_a == 15 && $urandom_range(0, 2) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            zero = 1'($urandom);
            if (m_boot[1] || m_idx[1] == 0) begin
                case ($urandom_range(0, 7))
                    0: nop = OP_R;
                    1: nop = OP_LW;
                    2: nop = OP_SW;
                    3: nop = OP_BEQ;
                    4: nop = OP_ADDI;
                    5: nop = OP_J;
                    6: nop = OP_BAD;
                    default: nop = 6'($urandom);
                endcase
                opcode = nop;
            end
            #1;
            check("rnd_a_state", 64'(a_state), 64'(st_a));
            check("rnd_a_outs", 64'(a_outs), 64'(exp_outs(st_a, mem_ready)));
            check("rnd_a_count", 64'(a_cnt), m_cnt[0]);
            check("rnd_b_state", 64'(b_state), 64'(st_b));
            check("rnd_b_outs", 64'(b_outs), 64'(exp_outs(st_b, mem_ready)));
            check("rnd_b_count", 64'(b_cnt), m_cnt[1]);
            @(posedge clk);
            model_step(0, rst, mem_ready, opcode);
            model_step(1, rst, mem_ready, opcode);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
